// File: rtl/dhvajanka_pkg.sv
// Shared types and constants for the Dhvajanka divider front-end.
// Holds the sequencer state encoding, the result error codes and the two power-of-10 bases.
package dhvajanka_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLASSIFY,
        ISSUE,
        WAIT,
        RESP
    } prep_state_t;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_DIV0    = 2'b01,
        ERR_TIMEOUT = 2'b10
    } err_t;

    localparam logic [7:0] P10_LO = 8'd10;
    localparam logic [7:0] P10_HI = 8'd100;

endpackage

// File: rtl/dhvajanka_base_select.sv
// Combinational base selection for the Dhvajanka divider.
// Maps a divisor to its power-of-10 base, signed difference, iteration count and trivial-case flags.
module dhvajanka_base_select
    import dhvajanka_pkg::*;
#(
    parameter int BASE_THRESH = 32,
    parameter int MAX_ITER    = 3
) (
    input  logic [7:0]        i_divisor,
    output logic [7:0]        o_power10,
    output logic signed [8:0] o_difference,
    output logic [2:0]        o_max_iter,
    output logic              o_is_zero,
    output logic              o_is_one
);

    localparam logic [8:0] THRESH = 9'(BASE_THRESH);
    localparam logic [2:0] ITER   = 3'(MAX_ITER);

    // Both operands are zero-extended to 9 bits, so the subtraction cannot wrap.
    always_comb begin
        o_power10    = ({1'b0, i_divisor} < THRESH) ? P10_LO : P10_HI;
        o_difference = $signed({1'b0, o_power10}) - $signed({1'b0, i_divisor});
        o_max_iter   = (o_difference == 9'sd0) ? 3'd0 : ITER;
        o_is_zero    = (i_divisor == 8'd0);
        o_is_one     = (i_divisor == 8'd1);
    end

endmodule

// File: rtl/dhvajanka_operand_prep_8bit.sv
// Front-end sequencer for the 8-bit Dhvajanka divider: accepts operands, prepares the base,
// starts the compute stage, waits for completion (with timeout) and returns the result.
module dhvajanka_operand_prep_8bit
    import dhvajanka_pkg::*;
#(
    parameter int BASE_THRESH = 32,
    parameter int MAX_ITER    = 3,
    parameter int TIMEOUT     = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_dividend,
    input  logic [7:0]        in_divisor,
    output logic              dv_start,
    output logic [7:0]        dv_dividend,
    output logic [7:0]        dv_power10,
    output logic signed [8:0] dv_difference,
    output logic [2:0]        dv_max_iter,
    input  logic [7:0]        dv_quotient,
    input  logic [7:0]        dv_remainder,
    input  logic              dv_done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_quotient,
    output logic [7:0]        out_remainder,
    output logic [1:0]        out_err
);

    localparam int               CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    prep_state_t       r_state;
    prep_state_t       w_state_next;
    logic [7:0]        r_dividend;
    logic [7:0]        r_divisor;
    logic [7:0]        r_power10;
    logic signed [8:0] r_difference;
    logic [2:0]        r_max_iter;
    logic [7:0]        r_quotient;
    logic [7:0]        r_remainder;
    err_t              r_err;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_timeout;
    logic [7:0]        w_power10;
    logic signed [8:0] w_difference;
    logic [2:0]        w_max_iter;
    logic              w_is_zero;
    logic              w_is_one;

    dhvajanka_base_select #(
        .BASE_THRESH (BASE_THRESH),
        .MAX_ITER    (MAX_ITER)
    ) u_base_select (
        .i_divisor    (r_divisor),
        .o_power10    (w_power10),
        .o_difference (w_difference),
        .o_max_iter   (w_max_iter),
        .o_is_zero    (w_is_zero),
        .o_is_one     (w_is_one)
    );

    // A completion in the same cycle as the last count always takes priority over the timeout.
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_timeout = !dv_done && (w_cnt_inc == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        dv_start     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_next = CLASSIFY;
            end
            CLASSIFY: begin
                w_state_next = (w_is_zero || w_is_one) ? RESP : ISSUE;
            end
            ISSUE: begin
                dv_start     = 1'b1;
                w_state_next = WAIT;
            end
            WAIT: begin
                if (dv_done || w_timeout) w_state_next = RESP;
            end
            RESP: begin
                out_valid = 1'b1;
                if (out_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Operand, compute-stage and result registers; all cleared so outputs read 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dividend   <= 8'd0;
            r_divisor    <= 8'd0;
            r_power10    <= 8'd0;
            r_difference <= 9'sd0;
            r_max_iter   <= 3'd0;
            r_quotient   <= 8'd0;
            r_remainder  <= 8'd0;
            r_err        <= ERR_OK;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_dividend <= in_dividend;
                        r_divisor  <= in_divisor;
                    end
                end
                CLASSIFY: begin
                    if (w_is_zero) begin
                        r_quotient  <= 8'd0;
                        r_remainder <= 8'd0;
                        r_err       <= ERR_DIV0;
                    end else if (w_is_one) begin
                        r_quotient  <= r_dividend;
                        r_remainder <= 8'd0;
                        r_err       <= ERR_OK;
                    end else begin
                        r_power10    <= w_power10;
                        r_difference <= w_difference;
                        r_max_iter   <= w_max_iter;
                    end
                end
                ISSUE: begin
                    r_cnt <= '0;
                end
                WAIT: begin
                    if (dv_done) begin
                        r_quotient  <= dv_quotient;
                        r_remainder <= dv_remainder;
                        r_err       <= ERR_OK;
                    end else if (w_timeout) begin
                        r_quotient  <= 8'd0;
                        r_remainder <= 8'd0;
                        r_err       <= ERR_TIMEOUT;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dv_dividend   = r_dividend;
    assign dv_power10    = r_power10;
    assign dv_difference = r_difference;
    assign dv_max_iter   = r_max_iter;
    assign out_quotient  = r_quotient;
    assign out_remainder = r_remainder;
    assign out_err       = r_err;

endmodule

// File: tb/tb_dhvajanka_operand_prep_8bit.sv
// Bench for the Dhvajanka operand sequencer: acts as the compute stage and result consumer,
// comparing every transaction against an arithmetic reference model.
module tb_dhvajanka_operand_prep_8bit;

    localparam int TIMEOUT = 64;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_dividend;
    logic [7:0]        in_divisor;
    logic              dv_start;
    logic [7:0]        dv_dividend;
    logic [7:0]        dv_power10;
    logic signed [8:0] dv_difference;
    logic [2:0]        dv_max_iter;
    logic [7:0]        dv_quotient;
    logic [7:0]        dv_remainder;
    logic              dv_done;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_quotient;
    logic [7:0]        out_remainder;
    logic [1:0]        out_err;

    int checks = 0;
    int errors = 0;

    dhvajanka_operand_prep_8bit #(
        .BASE_THRESH (32),
        .MAX_ITER    (3),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_dividend   (in_dividend),
        .in_divisor    (in_divisor),
        .dv_start      (dv_start),
        .dv_dividend   (dv_dividend),
        .dv_power10    (dv_power10),
        .dv_difference (dv_difference),
        .dv_max_iter   (dv_max_iter),
        .dv_quotient   (dv_quotient),
        .dv_remainder  (dv_remainder),
        .dv_done       (dv_done),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_quotient  (out_quotient),
        .out_remainder (out_remainder),
        .out_err       (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: what the block should report for a/b, straight from the divider rules.
    function automatic void model(input int a, input int b, output bit trivial, output int p10,
                                  output int diff, output int mi, output int q, output int r,
                                  output int err);
        trivial = (b <= 1);
        p10 = (b < 32) ? 10 : 100;
        diff = p10 - b;
        mi = (diff == 0) ? 0 : 3;
        if (b == 0) begin q = 0; r = 0; err = 1; end
        else begin q = a / b; r = a % b; err = 0; end
    endfunction

    // Drives one transaction as producer and compute stage; records what was observed.
    task automatic do_txn(input logic [7:0] a, input logic [7:0] b, input int done_lat,
                          input bit give_done, output int t_start, output int t_resp,
                          output int n_starts, output bit unstable, output int p10,
                          output int diff, output int mi, output int dvd);
        int cyc;
        int wait_n;
        t_start = -1; t_resp = -1; n_starts = 0; unstable = 0;
        p10 = 0; diff = 0; mi = 0; dvd = 0; wait_n = 0;
        while (!in_ready && wait_n < 100) begin
            step();
            wait_n++;
        end
        in_valid = 1'b1; in_dividend = a; in_divisor = b;
        step();
        in_valid = 1'b0; in_dividend = 8'($urandom); in_divisor = 8'($urandom);
        cyc = 1;
        while (cyc < TIMEOUT + 20) begin
            if (out_valid) begin
                t_resp = cyc;
                break;
            end
            if (dv_start) begin
                n_starts++;
                if (t_start < 0) begin
                    t_start = cyc; p10 = int'(dv_power10); diff = int'(dv_difference);
                    mi = int'(dv_max_iter); dvd = int'(dv_dividend);
                end
            end else if (t_start >= 0) begin
                if (int'(dv_power10) != p10 || int'(dv_difference) != diff ||
                    int'(dv_max_iter) != mi || int'(dv_dividend) != dvd) unstable = 1;
            end
            dv_done = give_done && (t_start >= 0) && (cyc == t_start + done_lat) && (b != 0);
            if (dv_done) begin
                dv_quotient = a / b; dv_remainder = a % b;
            end
            step();
            cyc++;
        end
        dv_done = 1'b0;
    endtask

    task automatic release_resp();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || dv_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got in_ready=%b out_valid=%b dv_start=%b exp 1 0 0",
                     in_ready, out_valid, dv_start);
        end
        checks++;
        if ({out_quotient, out_remainder, out_err} !== 18'd0) begin
            errors++;
            $display("FAIL reset_out got q=%0d r=%0d err=%0d exp 0 0 0",
                     out_quotient, out_remainder, out_err);
        end
        checks++;
        if ({dv_dividend, dv_power10, dv_difference, dv_max_iter} !== 28'd0) begin
            errors++;
            $display("FAIL reset_dv got dvd=%0d p10=%0d diff=%0d mi=%0d exp all 0",
                     dv_dividend, dv_power10, dv_difference, dv_max_iter);
        end
    endtask

    task automatic test_base_98();
        int ts, tr, ns, p10, diff, mi, dvd;
        bit uns;
        do_txn(8'd200, 8'd98, 3, 1'b1, ts, tr, ns, uns, p10, diff, mi, dvd);
        checks++;
        if (ts !== 2 || ns !== 1) begin
            errors++;
            $display("FAIL b98_start got t_start=%0d starts=%0d exp 2 1", ts, ns);
        end
        checks++;
        if (p10 !== 100 || diff !== 2 || mi !== 3 || dvd !== 200 || uns) begin
            errors++;
            $display("FAIL b98_dv got p10=%0d diff=%0d mi=%0d dvd=%0d unstable=%0d exp 100 2 3 200 0",
                     p10, diff, mi, dvd, uns);
        end
        checks++;
        if (tr !== 6 || out_quotient !== 8'd2 || out_remainder !== 8'd4 || out_err !== 2'b00) begin
            errors++;
            $display("FAIL b98_out got t=%0d q=%0d r=%0d err=%0d exp 6 2 4 0",
                     tr, out_quotient, out_remainder, out_err);
        end
        release_resp();
    endtask

    task automatic test_base_select();
        logic [7:0] dvs [7] = '{8'd7, 8'd12, 8'd100, 8'd31, 8'd32, 8'd255, 8'd2};
        int ts, tr, ns, p10, diff, mi, dvd, ep, ed, em, eq, er, ee;
        bit uns, triv;
        for (int i = 0; i < 7; i++) begin
            model(50, int'(dvs[i]), triv, ep, ed, em, eq, er, ee);
            do_txn(8'd50, dvs[i], 1 + i % 3, 1'b1, ts, tr, ns, uns, p10, diff, mi, dvd);
            checks++;
            if (p10 !== ep || diff !== ed || mi !== em || uns) begin
                errors++;
                $display("FAIL base_sel_%0d got p10=%0d diff=%0d mi=%0d unstable=%0d exp %0d %0d %0d 0",
                         dvs[i], p10, diff, mi, uns, ep, ed, em);
            end
            checks++;
            if (int'(out_quotient) !== eq || int'(out_remainder) !== er || int'(out_err) !== ee) begin
                errors++;
                $display("FAIL base_res_%0d got q=%0d r=%0d err=%0d exp %0d %0d %0d",
                         dvs[i], out_quotient, out_remainder, out_err, eq, er, ee);
            end
            release_resp();
        end
    endtask

    task automatic test_trivial();
        int ts, tr, ns, p10, diff, mi, dvd;
        bit uns;
        do_txn(8'd77, 8'd0, 1, 1'b1, ts, tr, ns, uns, p10, diff, mi, dvd);
        checks++;
        if (ns !== 0 || tr !== 2 || out_quotient !== 8'd0 || out_remainder !== 8'd0 ||
            out_err !== 2'b01) begin
            errors++;
            $display("FAIL div0 got starts=%0d t=%0d q=%0d r=%0d err=%0d exp 0 2 0 0 1",
                     ns, tr, out_quotient, out_remainder, out_err);
        end
        release_resp();
        do_txn(8'd77, 8'd1, 1, 1'b1, ts, tr, ns, uns, p10, diff, mi, dvd);
        checks++;
        if (ns !== 0 || tr !== 2 || out_quotient !== 8'd77 || out_remainder !== 8'd0 ||
            out_err !== 2'b00) begin
            errors++;
            $display("FAIL div1 got starts=%0d t=%0d q=%0d r=%0d err=%0d exp 0 2 77 0 0",
                     ns, tr, out_quotient, out_remainder, out_err);
        end
        release_resp();
    endtask

    task automatic test_timeout();
        int ts, tr, ns, p10, diff, mi, dvd;
        bit uns;
        do_txn(8'd150, 8'd40, 0, 1'b0, ts, tr, ns, uns, p10, diff, mi, dvd);
        checks++;
        if (ts !== 2 || tr !== 2 + TIMEOUT || out_err !== 2'b10 || out_quotient !== 8'd0 ||
            out_remainder !== 8'd0) begin
            errors++;
            $display("FAIL timeout got t_start=%0d t=%0d err=%0d q=%0d r=%0d exp 2 %0d 2 0 0",
                     ts, tr, out_err, out_quotient, out_remainder, 2 + TIMEOUT);
        end
        dv_done = 1'b1; dv_quotient = 8'hAA; dv_remainder = 8'h55;
        step();
        dv_done = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_quotient !== 8'd0 || out_remainder !== 8'd0 ||
            out_err !== 2'b10) begin
            errors++;
            $display("FAIL stray_resp got v=%b q=%0d r=%0d err=%0d exp 1 0 0 2",
                     out_valid, out_quotient, out_remainder, out_err);
        end
        release_resp();
        dv_done = 1'b1;
        step();
        dv_done = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || dv_start !== 1'b0) begin
            errors++;
            $display("FAIL stray_idle got v=%b in_ready=%b start=%b exp 0 1 0",
                     out_valid, in_ready, dv_start);
        end
    endtask

    task automatic test_backpressure();
        int ts, tr, ns, p10, diff, mi, dvd;
        int bad;
        bit uns;
        do_txn(8'd123, 8'd10, 2, 1'b1, ts, tr, ns, uns, p10, diff, mi, dvd);
        checks++;
        if (p10 !== 10 || diff !== 0 || mi !== 0 || out_quotient !== 8'd12 ||
            out_remainder !== 8'd3) begin
            errors++;
            $display("FAIL bp_first got p10=%0d diff=%0d mi=%0d q=%0d r=%0d exp 10 0 0 12 3",
                     p10, diff, mi, out_quotient, out_remainder);
        end
        in_valid = 1'b1; in_dividend = 8'd5; in_divisor = 8'd5;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_quotient !== 8'd12 ||
                out_remainder !== 8'd3 || out_err !== 2'b00) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold got %0d unstable cycles exp 0", bad);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release got in_ready=%b v=%b exp 1 0", in_ready, out_valid);
        end
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if (dv_start !== 1'b1 || dv_dividend !== 8'd5 || dv_power10 !== 8'd10 ||
            dv_difference !== 9'sd5) begin
            errors++;
            $display("FAIL bp_next got start=%b dvd=%0d p10=%0d diff=%0d exp 1 5 10 5",
                     dv_start, dv_dividend, dv_power10, dv_difference);
        end
        step();
        dv_done = 1'b1; dv_quotient = 8'd1; dv_remainder = 8'd0;
        step();
        dv_done = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_quotient !== 8'd1 || out_remainder !== 8'd0) begin
            errors++;
            $display("FAIL bp_next_out got v=%b q=%0d r=%0d exp 1 1 0",
                     out_valid, out_quotient, out_remainder);
        end
        release_resp();
    endtask

    task automatic test_reset_in_wait();
        int ts, tr, ns, p10, diff, mi, dvd;
        bit uns;
        in_valid = 1'b1; in_dividend = 8'd200; in_divisor = 8'd98;
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if (dv_start !== 1'b1) begin
            errors++;
            $display("FAIL rw_start got %b exp 1", dv_start);
        end
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || dv_start !== 1'b0 ||
            {dv_dividend, dv_power10, dv_difference, dv_max_iter} !== 28'd0) begin
            errors++;
            $display("FAIL rw_reset got in_ready=%b v=%b p10=%0d diff=%0d mi=%0d exp 1 0 0 0 0",
                     in_ready, out_valid, dv_power10, dv_difference, dv_max_iter);
        end
        dv_done = 1'b1; dv_quotient = 8'd9; dv_remainder = 8'd9;
        step();
        dv_done = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rw_stray got v=%b in_ready=%b exp 0 1", out_valid, in_ready);
        end
        do_txn(8'd200, 8'd98, 2, 1'b1, ts, tr, ns, uns, p10, diff, mi, dvd);
        checks++;
        if (ts !== 2 || tr !== 5 || out_quotient !== 8'd2 || out_remainder !== 8'd4 ||
            out_err !== 2'b00) begin
            errors++;
            $display("FAIL rw_after got t_start=%0d t=%0d q=%0d r=%0d err=%0d exp 2 5 2 4 0",
                     ts, tr, out_quotient, out_remainder, out_err);
        end
        release_resp();
    endtask

    task automatic test_random();
        int ts, tr, ns, p10, diff, mi, dvd, ep, ed, em, eq, er, ee, lat;
        bit uns, triv;
        logic [7:0] a, b;
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom);
            b = (i % 4 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            lat = $urandom_range(1, 6);
            model(int'(a), int'(b), triv, ep, ed, em, eq, er, ee);
            do_txn(a, b, lat, 1'b1, ts, tr, ns, uns, p10, diff, mi, dvd);
            checks++;
            if (triv ? (ns !== 0 || tr !== 2)
                     : (ns !== 1 || ts !== 2 || tr !== 3 + lat || p10 !== ep || diff !== ed ||
                        mi !== em || dvd !== int'(a) || uns)) begin
                errors++;
                $display("FAIL rnd_seq %0d/%0d got starts=%0d ts=%0d t=%0d p10=%0d diff=%0d mi=%0d exp p10=%0d diff=%0d mi=%0d lat=%0d",
                         a, b, ns, ts, tr, p10, diff, mi, ep, ed, em, lat);
            end
            checks++;
            if (int'(out_quotient) !== eq || int'(out_remainder) !== er || int'(out_err) !== ee) begin
                errors++;
                $display("FAIL rnd_res %0d/%0d got q=%0d r=%0d err=%0d exp %0d %0d %0d",
                         a, b, out_quotient, out_remainder, out_err, eq, er, ee);
            end
            release_resp();
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_dividend = 8'd0; in_divisor = 8'd0;
        dv_quotient = 8'd0; dv_remainder = 8'd0; dv_done = 1'b0; out_ready = 1'b0;
        test_reset();
        test_base_98();
        test_base_select();
        test_trivial();
        test_timeout();
        test_backpressure();
        test_reset_in_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
